// File: rtl/dense_layer_seq.sv
// Sequencer for one fully-connected layer: fetches each weight row and bias, drives the
// dot-product PE through its start/done handshake, then applies ReLU and a saturating requantize.
module dense_layer_seq #(
    parameter int VECTOR_LENGTH = 16,
    parameter int NUM_NEURONS   = 8,
    parameter int W             = 8,
    parameter int ACC_WIDTH     = W + 7,
    parameter int SHIFT         = 4,
    parameter int ADDR_W        = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           layer_start,
    input  logic [W*VECTOR_LENGTH-1:0]     in_vector_flat,
    output logic [ADDR_W-1:0]              w_rd_addr,
    input  logic [W*VECTOR_LENGTH-1:0]     w_rd_data,
    input  logic [W-1:0]                   b_rd_data,
    output logic                           pe_start,
    output logic [W*VECTOR_LENGTH-1:0]     pe_in_vector_flat,
    output logic [W*VECTOR_LENGTH-1:0]     pe_weight_row_flat,
    output logic [W-1:0]                   pe_bias,
    input  logic [ACC_WIDTH-1:0]           pe_result,
    input  logic                           pe_done,
    output logic [W*NUM_NEURONS-1:0]       out_vector_flat,
    output logic                           out_valid,
    output logic                           busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STORE  = 3'd4
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] QMAX_ACC = ACC_WIDTH'(2 ** (W - 1) - 1);
    localparam logic [W-1:0]                QMAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [ADDR_W-1:0]           LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_t                          state_r;
    logic [ADDR_W-1:0]               idx_r;
    logic [W*VECTOR_LENGTH-1:0]      in_latch_r;
    logic signed [ACC_WIDTH-1:0]     result_r;
    logic [ADDR_W-1:0]               w_rd_addr_r;
    logic                            pe_start_r;
    logic [W*VECTOR_LENGTH-1:0]      pe_in_r;
    logic [W*VECTOR_LENGTH-1:0]      pe_weight_r;
    logic [W-1:0]                    pe_bias_r;
    logic [W*NUM_NEURONS-1:0]        out_vector_r;
    logic                            out_valid_r;
    logic                            busy_r;
    logic [W-1:0]                    q_s;

    // ReLU, arithmetic shift, then clamp into the positive range of a W-bit signed value.
    function automatic logic [W-1:0] requant(input logic signed [ACC_WIDTH-1:0] r);
        logic signed [ACC_WIDTH-1:0] t;
        t = r >>> SHIFT;
        if (r[ACC_WIDTH-1]) begin
            requant = '0;
        end else if (t > QMAX_ACC) begin
            requant = QMAX;
        end else begin
            requant = t[W-1:0];
        end
    endfunction

    // Requantized value of the captured PE result, written into the output slot in STORE.
    always_comb begin
        q_s = '0;
        q_s = requant(result_r);
    end

    // Layer FSM; every output is a register updated alongside the state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= '0;
            in_latch_r   <= '0;
            result_r     <= '0;
            w_rd_addr_r  <= '0;
            pe_start_r   <= 1'b0;
            pe_in_r      <= '0;
            pe_weight_r  <= '0;
            pe_bias_r    <= '0;
            out_vector_r <= '0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (layer_start) begin
                        in_latch_r  <= in_vector_flat;
                        idx_r       <= '0;
                        w_rd_addr_r <= '0;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_FETCH;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    // Start is raised on entry to LAUNCH so it is high for exactly that cycle.
                    pe_start_r <= 1'b1;
                    state_r    <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    pe_start_r  <= 1'b0;
                    pe_weight_r <= w_rd_data;
                    pe_bias_r   <= b_rd_data;
                    pe_in_r     <= in_latch_r;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pe_done) begin
                        result_r <= pe_result;
                        state_r  <= ST_STORE;
                    end else begin
                        state_r  <= ST_WAIT;
                    end
                end
                ST_STORE: begin
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        if (idx_r == ADDR_W'(n)) begin
                            out_vector_r[n*W +: W] <= q_s;
                        end
                    end
                    if (idx_r == LAST_IDX) begin
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        idx_r       <= idx_r + ADDR_W'(1);
                        w_rd_addr_r <= idx_r + ADDR_W'(1);
                        state_r     <= ST_FETCH;
                    end
                end
                default: begin
                    pe_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_rd_addr          = w_rd_addr_r;
    assign pe_start           = pe_start_r;
    assign pe_in_vector_flat  = pe_in_r;
    assign pe_weight_row_flat = pe_weight_r;
    assign pe_bias            = pe_bias_r;
    assign out_vector_flat    = out_vector_r;
    assign out_valid          = out_valid_r;
    assign busy               = busy_r;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq with a behavioural weight ROM and dot-product PE
// (done VECTOR_LENGTH edges after start, optional per-neuron stall, result saturated to ACC_WIDTH).
module tb_dense_layer_seq;

    localparam int VL  = 16;
    localparam int NN  = 8;
    localparam int W   = 8;
    localparam int ACC = W + 7;
    localparam int AW  = 3;

    typedef struct {
        logic [7:0]  in_elem;
        logic [63:0] w_elems;
        logic [63:0] biases;
        logic [63:0] exp_out;
        int          stall_n;
        int          stall_c;
        int          poke_n;
        int          exp_lat;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 layer_start;
    logic [W*VL-1:0]      in_vector_flat;
    logic [AW-1:0]        w_rd_addr;
    logic [W*VL-1:0]      w_rd_data = '0;
    logic [W-1:0]         b_rd_data = '0;
    logic                 pe_start;
    logic [W*VL-1:0]      pe_in_vector_flat;
    logic [W*VL-1:0]      pe_weight_row_flat;
    logic [W-1:0]         pe_bias;
    logic [ACC-1:0]       pe_result = '0;
    logic                 pe_done = 1'b0;
    logic [W*NN-1:0]      out_vector_flat;
    logic                 out_valid;
    logic                 busy;

    logic [W*VL-1:0]      rom_w [NN];
    logic [W-1:0]         rom_b [NN];
    int                   stall_neuron = -1;
    int                   stall_cyc = 0;
    int                   pe_cnt = 0;
    int                   pe_extra = 0;
    bit                   pe_run = 1'b0;

    int                   n_cmp = 0;
    int                   n_fail = 0;
    vec_t                 vecs [4];
    int                   lat;

    dense_layer_seq dut (
        .clk                (clk),
        .reset              (reset),
        .layer_start        (layer_start),
        .in_vector_flat     (in_vector_flat),
        .w_rd_addr          (w_rd_addr),
        .w_rd_data          (w_rd_data),
        .b_rd_data          (b_rd_data),
        .pe_start           (pe_start),
        .pe_in_vector_flat  (pe_in_vector_flat),
        .pe_weight_row_flat (pe_weight_row_flat),
        .pe_bias            (pe_bias),
        .pe_result          (pe_result),
        .pe_done            (pe_done),
        .out_vector_flat    (out_vector_flat),
        .out_valid          (out_valid),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [ACC-1:0] pe_calc(input logic [W*VL-1:0] iv, input logic [W*VL-1:0] wv,
                                               input logic [W-1:0] b);
        int acc;
        int a;
        int m;
        acc = $signed(b);
        for (int i = 0; i < VL; i++) begin
            a = $signed(iv[i*W +: W]);
            m = $signed(wv[i*W +: W]);
            acc = acc + a * m;
        end
        if (acc > 2 ** (ACC - 1) - 1) acc = 2 ** (ACC - 1) - 1;
        if (acc < -(2 ** (ACC - 1))) acc = -(2 ** (ACC - 1));
        return acc[ACC-1:0];
    endfunction

    // Synchronous weight/bias memory with one cycle of read latency.
    always @(posedge clk) begin
        w_rd_data <= rom_w[w_rd_addr];
        b_rd_data <= rom_b[w_rd_addr];
    end

    // Behavioural PE: start clears done; done rises VL (+stall) edges later.
    always @(posedge clk) begin
        if (pe_start) begin
            pe_done  <= 1'b0;
            pe_run   <= 1'b1;
            pe_cnt   <= 1;
            pe_extra <= (int'(w_rd_addr) == stall_neuron) ? stall_cyc : 0;
        end else if (pe_run) begin
            if (pe_cnt >= VL + pe_extra) begin
                pe_done   <= 1'b1;
                pe_result <= pe_calc(pe_in_vector_flat, pe_weight_row_flat, pe_bias);
                pe_run    <= 1'b0;
            end else begin
                pe_cnt <= pe_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_rom(input vec_t v);
        for (int n = 0; n < NN; n++) begin
            rom_w[n] = {VL{v.w_elems[n*8 +: 8]}};
            rom_b[n] = v.biases[n*8 +: 8];
        end
        stall_neuron = v.stall_n;
        stall_cyc    = v.stall_c;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_vector"}, out_vector_flat, '0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_w_rd_addr"}, w_rd_addr, '0);
        chk({tag, "_pe_start"}, pe_start, 1'b0);
        chk({tag, "_pe_in"}, pe_in_vector_flat, '0);
        chk({tag, "_pe_weight"}, pe_weight_row_flat, '0);
        chk({tag, "_pe_bias"}, pe_bias, '0);
    endtask

    // Watches one layer from just after its accept edge up to out_valid (bounded).
    task automatic watch(input vec_t v, input bit hold, output int lat_o);
        int  cyc;
        int  pulses;
        bit  prev_ps;
        bit  poked;
        bit  fin;
        cyc = 0; pulses = 0; prev_ps = 1'b0; poked = 1'b0; fin = 1'b0;
        while (!fin && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            layer_start = hold;
            if (!poked && v.poke_n >= 0 && pulses == v.poke_n + 1 && !pe_start) begin
                layer_start = 1'b1;
                poked = 1'b1;
            end
            chk("busy_level", busy, (cyc < v.exp_lat));
            if (pe_start) begin
                pulses++;
                chk("pe_start_single", prev_ps, 1'b0);
                chk("w_rd_addr_idx", w_rd_addr, pulses - 1);
            end else if (pulses >= 1 && pulses <= NN) begin
                chk("pe_weight_held", pe_weight_row_flat, rom_w[pulses-1]);
                chk("pe_bias_held", pe_bias, rom_b[pulses-1]);
                chk("pe_in_held", pe_in_vector_flat, {VL{v.in_elem}});
            end
            prev_ps = pe_start;
            if (out_valid) fin = 1'b1;
        end
        chk("layer_completed", fin, 1'b1);
        chk("latency", cyc, v.exp_lat);
        chk("pe_start_pulses", pulses, NN);
        chk("out_vector", out_vector_flat, v.exp_out);
        lat_o = cyc;
    endtask

    task automatic run_layer(input vec_t v, input bit hold, output int lat_o);
        load_rom(v);
        in_vector_flat = {VL{v.in_elem}};
        layer_start = 1'b1;
        @(posedge clk);
        watch(v, hold, lat_o);
        if (!hold) begin
            repeat (3) @(negedge clk);
            chk("out_valid_level", out_valid, 1'b1);
            chk("out_vector_kept", out_vector_flat, v.exp_out);
        end
    endtask

    initial begin
        vecs[0] = '{8'h01, 64'h0202020202020202, 64'h0, 64'h0202020202020202, -1, 0, -1, 160};
        vecs[1] = '{8'h01, 64'h02020202FF020202, 64'h0, 64'h0202020200020202, -1, 0, 4, 160};
        vecs[2] = '{8'h7F, 64'h02007F00FF000101, 64'h007F7F10000FFF10, 64'h7F077F0100007E7F, -1, 0, -1, 160};
        vecs[3] = '{8'hFE, 64'hFDFDFDFDFDFDFDFD, 64'h0706050403020100, 64'h0606060606060606, 2, 7, -1, 167};

        reset = 1'b1;
        layer_start = 1'b0;
        in_vector_flat = '0;
        for (int n = 0; n < NN; n++) begin
            rom_w[n] = '0;
            rom_b[n] = '0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk_zero_outputs("idle");

        for (int i = 0; i < 4; i++) begin
            run_layer(vecs[i], 1'b0, lat);
            @(negedge clk);
        end

        // layer_start held high: re-accepted in the one IDLE cycle after completion.
        run_layer(vecs[0], 1'b1, lat);
        @(posedge clk);
        @(negedge clk);
        chk("hold_out_valid_one_cycle", out_valid, 1'b0);
        chk("hold_busy_again", busy, 1'b1);
        layer_start = 1'b0;
        watch(vecs[0], 1'b0, lat);
        @(negedge clk);

        // Asynchronous reset in the WAIT state of neuron 6.
        load_rom(vecs[2]);
        in_vector_flat = {VL{vecs[2].in_elem}};
        layer_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        layer_start = 1'b0;
        repeat (129) @(posedge clk);
        #3;
        chk("busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk_zero_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_out_vector", out_vector_flat, '0);
        run_layer(vecs[3], 1'b0, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
